// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared constants, width helper and vector typedefs for the
//                parametrised unsigned FIR filter.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    // Value every coefficient takes after reset: the filter is a moving sum.
    localparam int COEF_RESET      = 1;

    // Default configuration of the filter.
    localparam int DEF_INPUT_WIDTH = 14;
    localparam int DEF_COEF_WIDTH  = 14;
    localparam int DEF_NUM_TAPS    = 8;

    // Result width that can hold the sum of all taps without overflow.
    function automatic int fir_out_width(input int in_w, input int coef_w, input int taps);
        return in_w + coef_w + $clog2(taps);
    endfunction

    // Tap and product vectors for the default configuration.
    typedef logic [DEF_NUM_TAPS-1:0][DEF_INPUT_WIDTH-1:0]                tap_vec_t;
    typedef logic [DEF_NUM_TAPS-1:0][DEF_INPUT_WIDTH+DEF_COEF_WIDTH-1:0] prod_vec_t;

endpackage
`default_nettype wire

// File: rtl/fir_mult_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mult_stage
//  Description : Registered unsigned multiplier, one per filter tap.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mult_stage #(
    parameter int A_WIDTH = 14,
    parameter int B_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [A_WIDTH-1:0]         i_a,
    input  logic [B_WIDTH-1:0]         i_b,
    output logic [A_WIDTH+B_WIDTH-1:0] o_p
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [P_WIDTH-1:0] r_p;

    // Full-width product registered every cycle; the pipeline never stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p <= '0;
        end else begin
            r_p <= P_WIDTH'(i_a) * P_WIDTH'(i_b);
        end
    end

    assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/param_unsigned_fir.sv
`default_nettype none
// ============================================================================
//  Module      : param_unsigned_fir
//  Description : N-tap unsigned direct-form FIR. Three stages: delay line (S0),
//                registered products (S1), registered adder tree (S2).
//                Run-time coefficient writes and a synchronous flush.
//  Revision    : 1.0  initial release
// ============================================================================
module param_unsigned_fir
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
    parameter int NUM_TAPS     = DEF_NUM_TAPS,
    parameter int OUTPUT_WIDTH = fir_out_width(INPUT_WIDTH, COEF_WIDTH, NUM_TAPS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic [INPUT_WIDTH-1:0]      x,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]       coef_data,
    output logic                        y_valid,
    output logic [OUTPUT_WIDTH-1:0]     y
);

    localparam int ADDR_WIDTH = $clog2(NUM_TAPS);
    localparam int PROD_WIDTH = INPUT_WIDTH + COEF_WIDTH;

    logic [NUM_TAPS-1:0][INPUT_WIDTH-1:0] r_tap;
    logic [NUM_TAPS-1:0][COEF_WIDTH-1:0]  r_coef;
    logic                                 r_v0;
    logic                                 r_v1;
    logic [PROD_WIDTH-1:0]                w_prod [NUM_TAPS];
    logic [OUTPUT_WIDTH-1:0]              w_sum;
    logic [OUTPUT_WIDTH-1:0]              r_y;
    logic                                 r_y_valid;

    // Coefficient register file; S1 reads the pre-write value on a write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= COEF_WIDTH'(COEF_RESET);
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (coef_we && (coef_addr == ADDR_WIDTH'(i))) begin
                    r_coef[i] <= coef_data;
                end
            end
        end
    end

    // S0 delay line: shift only on accepted samples; clear wins over in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tap <= '0;
            r_v0  <= 1'b0;
        end else if (clear) begin
            r_tap <= '0;
            r_v0  <= 1'b0;
        end else begin
            r_v0 <= in_valid;
            if (in_valid) begin
                r_tap <= {r_tap[NUM_TAPS-2:0], x};
            end
        end
    end

    // S1 products, one registered multiplier per tap.
    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_mult
        fir_mult_stage #(
            .A_WIDTH (INPUT_WIDTH),
            .B_WIDTH (COEF_WIDTH)
        ) u_mult (
            .clk   (clk),
            .reset (reset),
            .i_a   (r_tap[g]),
            .i_b   (r_coef[g]),
            .o_p   (w_prod[g])
        );
    end

    // S1 valid tracks the products; a flush kills it along with v0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
        end else if (clear) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
        end
    end

    // Adder tree over all products at full output width, so no overflow.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_sum = w_sum + OUTPUT_WIDTH'(w_prod[i]);
        end
    end

    // S2 output register: y holds between valid results; unaffected by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= r_v1;
            if (r_v1) begin
                r_y <= w_sum;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_param_unsigned_fir.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_unsigned_fir
//  Description : Scoreboard bench for param_unsigned_fir (default widths).
//                Stimulus pushes hand-computed results tagged with the cycle
//                they must appear in; a negedge monitor pops and compares.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_unsigned_fir;
    import fir_pkg::*;

    localparam int IW = 14;
    localparam int CW = 14;
    localparam int NT = 8;
    localparam int OW = 31;

    typedef struct {
        logic [OW-1:0] val;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [IW-1:0] x;
    logic          coef_we;
    logic [2:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic          y_valid;
    logic [OW-1:0] y;

    exp_t q[$];
    int   cyc;
    int   n_checks;
    int   n_errors;

    param_unsigned_fir #(
        .INPUT_WIDTH  (IW),
        .COEF_WIDTH   (CW),
        .NUM_TAPS     (NT),
        .OUTPUT_WIDTH (OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .x         (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .y_valid   (y_valid),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (!reset && y_valid) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got y=%0d at cycle %0d, required no output", y, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (y !== e.val || cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL y_result: got y=%0d at cycle %0d, required y=%0d at cycle %0d",
                             y, cyc, e.val, e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Present one sample for one cycle; optionally expect its result 3 cycles later.
    task automatic issue(input logic [IW-1:0] xv, input bit push, input logic [OW-1:0] ev);
        exp_t e;
        in_valid = 1'b1;
        x        = xv;
        if (push) begin
            e.val = ev;
            e.cyc = cyc + 3;
            q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        x        = '0;
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [CW-1:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        step();
        coef_we   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [OW-1:0] big [8];
        logic [OW-1:0] ramp [9];
        tap_vec_t      unused_taps;
        big  = '{31'd268402689, 31'd536805378, 31'd805208067, 31'd1073610756,
                 31'd1342013445, 31'd1610416134, 31'd1878818823, 31'd2147221512};
        ramp = '{31'd1, 31'd3, 31'd6, 31'd10, 31'd15, 31'd21, 31'd28, 31'd36, 31'd44};
        unused_taps = '0;

        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;

        // Reset state
        idle(2);
        check("reset_y", y, '0);
        check("reset_y_valid", {30'd0, y_valid}, '0);
        reset = 1'b0;
        idle(2);

        // Moving sum with reset coefficients, x = 1..9 back-to-back
        for (int i = 0; i < 9; i++) issue(IW'(i + 1), 1'b1, ramp[i]);
        idle(5);
        do_clear();

        // Ramp coefficients c[i]=i+1, impulse of 5 then zeros
        for (int i = 0; i < NT; i++) wr_coef(3'(i), CW'(i + 1));
        idle(1);
        issue(14'd5, 1'b1, 31'd5);
        for (int i = 1; i < 8; i++) issue(14'd0, 1'b1, OW'(5 * (i + 1)));
        issue(14'd0, 1'b1, 31'd0);
        idle(5);
        do_clear();

        // Full-scale coefficients and samples: no wrap in 31 bits
        for (int i = 0; i < NT; i++) wr_coef(3'(i), 14'h3FFF);
        idle(1);
        for (int i = 0; i < 8; i++) issue(14'h3FFF, 1'b1, big[i]);
        idle(5);
        do_clear();

        // Sparse input: y_valid must mirror the gaps
        for (int i = 0; i < NT; i++) wr_coef(3'(i), 14'd1);
        idle(1);
        issue(14'd2, 1'b1, 31'd2);
        idle(1);
        issue(14'd4, 1'b1, 31'd6);
        idle(1);
        issue(14'd6, 1'b1, 31'd12);
        idle(5);
        do_clear();
        idle(2);

        // Flush with samples in flight: x=10 survives, 20 and 30 are lost
        issue(14'd10, 1'b1, 31'd10);
        issue(14'd20, 1'b0, '0);
        clear    = 1'b1;
        in_valid = 1'b1;
        x        = 14'd30;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        issue(14'd7, 1'b1, 31'd7);
        idle(6);

        // Asynchronous reset mid-stream after loading coefficients of 3
        for (int i = 0; i < NT; i++) wr_coef(3'(i), 14'd3);
        do_clear();
        idle(1);
        issue(14'd2, 1'b1, 31'd6);
        issue(14'd2, 1'b0, '0);
        issue(14'd2, 1'b0, '0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_y", y, '0);
        check("async_reset_y_valid", {30'd0, y_valid}, '0);
        step();
        reset = 1'b0;
        idle(1);
        issue(14'd4, 1'b1, 31'd4);
        idle(6);

        // Every expected result must have been delivered
        check("scoreboard_drained", OW'(q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
